i2c_eeprom_slave: RTL and testbench
===================================

# i2c_eeprom_slave

Synthesizable I2C responder that models a 24C02-class serial EEPROM: 7-bit device address, 8-bit word address, byte/sequential write and current/random/sequential read. It is the far end of the EEPROM I2C link driven by `eeprom_test`. It replaces the tie-off SDA driver in simulation and can also serve as an on-FPGA loopback target. The block oversamples SCL/SDA on `CLK_50M`; it never drives SCL.

## Interface
- `DEV_ADDR`, default 7'h50: device address matched against the first byte after START.
- `MEM_DEPTH`, default 256: number of bytes; the word address is 8 bits and the pointer wraps modulo `MEM_DEPTH`.
- `CLK_50M` input, 1 bit: system clock, the only clock.
- `RSTn` input, 1 bit: synchronous, active-low reset.
- `SCL` input, 1 bit: I2C clock from the master.
- `SDA_IN` input, 1 bit: sampled SDA line level.
- `SDA_OE` output, 1 bit: 1 pulls SDA low (open-drain). The bench or top level resolves the line as `SDA = SDA_OE ? 0 : z` with a pull-up.
- `BUSY` output, 1 bit: 1 from an address-matched START until STOP or NACK-return-to-IDLE.
- `WR_PULSE` output, 1 bit: one-cycle strobe when a data byte is committed to memory.

## Operation
- **Input conditioning**
  - `SCL` and `SDA_IN` each pass through a 2-flop synchronizer, then a 1-flop history register.
  - Derived events: `scl_rise`, `scl_fall`, `start` (SDA 1→0 while SCL=1), `stop` (SDA 0→1 while SCL=1).
- **Bit timing**
  - Receive bits are sampled on `scl_rise`, MSB first.
  - `SDA_OE` changes only on `scl_fall`, except for reset and STOP, which release it immediately.
- **States:** IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK. A 3-bit bit counter and an 8-bit shift register are used.
- **START from any state:** go to DEV, bit counter cleared.
- **STOP from any state:** go to IDLE, `SDA_OE`=0, partial byte discarded.
- **DEV:** after 8 bits, compare `[7:1]` with `DEV_ADDR`.
  - Match: go to DEV_ACK and latch R/W.
  - Mismatch: go to IDLE with no ACK.
- **DEV_ACK:** assert `SDA_OE` on the `scl_fall` after bit 8 and release it on the next `scl_fall`. Then:
  - W=0: go to WADDR.
  - R=1: go to RDATA.
- **WADDR:** after 8 bits, pointer ← byte; go to WADDR_ACK (ACK as above), then WDATA.
- **WDATA:** after 8 bits, `mem[pointer]` ← byte, `WR_PULSE`=1 for one cycle, pointer ← pointer+1 (wraps). Go to WDATA_ACK, ACK, then WDATA again.
- **RDATA:**
  - On the `scl_fall` ending the previous ACK slot, load shift register ← `mem[pointer]` and pointer ← pointer+1.
  - Drive `SDA_OE` = ~bit[7]; shift on each subsequent `scl_fall`.
  - After 8 bits, release SDA and go to RD_MACK.
- **RD_MACK:** sample SDA on `scl_rise`.
  - 0 (ACK): go to RDATA for the next byte.
  - 1 (NACK): go to IDLE and leave SDA released.
- **Random read** is handled naturally: write the word address, then a repeated START with R=1 reads from the pointer.
- **Memory** contents are not affected by `RSTn` and are undefined at power-up. The pointer resets to 0.

## Timing
- Reset values: `SDA_OE`=0, `BUSY`=0, `WR_PULSE`=0, state IDLE, pointer 0, synchronizer flops 1 (idle bus).
- Event latency: 3 `CLK_50M` cycles from a pin change to its detected event. `SDA_OE` updates on the cycle after the `scl_fall` detect, i.e. 4 cycles after the SCL pin falls. This is well inside the 400 kHz hold window.
- Read data: memory read is synchronous, 1 cycle. The byte is fetched on the RD_MACK/ACK-slot `scl_fall` and driven in the same cycle as a normal `SDA_OE` update.
- `start` and `scl_fall` detected in the same cycle: `start` wins.
- `RSTn` low mid-transfer: outputs take reset values on the next clock edge and the bus is released.

## Structure
- Package `i2c_eeprom_pkg`:
  - State enum.
  - Constants `ACK`=0, `NACK`=1.
  - Default `DEV_ADDR`.
- Sub-module `eeprom_mem`: single-port synchronous RAM, `MEM_DEPTH`×8, write enable plus registered read.
- The top level holds the synchronizers, event detection, FSM, bit counter, shift register and pointer.

## Test plan
- **Byte write:** START, 0xA0, 0x10, 0x5A, STOP → three ACKs (`SDA_OE`=1 in each 9th clock), one `WR_PULSE`, `mem[0x10]`=0x5A.
- **Random read:** START, 0xA0, 0x10, repeated START, 0xA1, read one byte, master NACK, STOP → SDA carries 0x5A MSB first; `SDA_OE`=0 after the NACK; pointer=0x11.
- **Address mismatch:** START, 0xA2 → no ACK; `SDA_OE` stays 0 and `BUSY` stays 0 through the following bytes and STOP.
- **Wrap:** write address 0xFE with data 0x11, 0x22, 0x33, then sequential read from 0xFE of 3 bytes with ACK, ACK, NACK → reads 0x11, 0x22, 0x33; `mem[0x00]`=0x33.
- **Abort:** STOP after 4 bits of a data byte → no `WR_PULSE`, memory unchanged, state IDLE.
- **Reset mid-read:** assert `RSTn` while `SDA_OE`=1 during a 0x00 data byte → `SDA_OE`=0 and `BUSY`=0 on the next clock; a following transaction works normally.

Source files
------------

// File: rtl/i2c_eeprom_pkg.sv
// Shared state encoding and bus constants for the I2C EEPROM responder.
package i2c_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK
  } state_t;

  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

endpackage

// File: rtl/eeprom_mem.sv
// Single-port byte RAM with registered read; contents survive reset.
module eeprom_mem
  import i2c_eeprom_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24C02-style I2C EEPROM responder, oversampling SCL/SDA on CLK_50M.
// MEM_DEPTH is expected to be a power of two no larger than 256.
//
// state        | meaning
// ST_IDLE      | bus free or transfer not addressed to us
// ST_DEV       | shifting in device address + R/W
// ST_DEV_ACK   | ACK slot after matched device address
// ST_WADDR     | shifting in word address
// ST_WADDR_ACK | ACK slot after word address
// ST_WDATA     | shifting in a write data byte
// ST_WDATA_ACK | ACK slot after a committed data byte
// ST_RDATA     | driving a read byte MSB first
// ST_RD_MACK   | master ACK/NACK slot after a read byte
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = 256
) (
  input  logic CLK_50M,
  input  logic RSTn,
  input  logic SCL,
  input  logic SDA_IN,
  output logic SDA_OE,
  output logic BUSY,
  output logic WR_PULSE
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_d, sda_d, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_ev, stop_ev;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n, byte_in, rdata;
  logic [AW-1:0] ptr, ptr_n, ptr_inc;
  logic          oe, oe_n, busy, busy_n, rw, rw_n;
  logic          mem_we, wr_pulse;

  always_ff @(posedge CLK_50M) begin
    if (!RSTn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA_IN};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_q    = scl_sync[1];
  assign sda_q    = sda_sync[1];
  assign scl_rise = scl_q & ~scl_d;
  assign scl_fall = ~scl_q & scl_d;
  assign start_ev = scl_q & scl_d & sda_d & ~sda_q;
  assign stop_ev  = scl_q & scl_d & ~sda_d & sda_q;

  assign byte_in = {shreg[6:0], sda_q};
  assign ptr_inc = ptr + AW'(1);

  eeprom_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_sys (CLK_50M),
    .we      (mem_we),
    .addr    (ptr),
    .wdata   (byte_in),
    .rdata   (rdata)
  );

  always_ff @(posedge CLK_50M) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ptr      <= ptr_n;
      oe       <= oe_n;
      busy     <= busy_n;
      rw       <= rw_n;
      wr_pulse <= mem_we;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    oe_n      = oe;
    busy_n    = busy;
    rw_n      = rw;
    mem_we    = 1'b0;
    if (start_ev) begin
      state_n   = ST_DEV;
      bit_cnt_n = '0;
    end else if (stop_ev) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_DEV, ST_WADDR, ST_WDATA: begin
          if (scl_fall) oe_n = 1'b0;
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_DEV) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_n = ST_DEV_ACK;
                  rw_n    = byte_in[0];
                  busy_n  = 1'b1;
                end else begin
                  state_n = ST_IDLE;
                  busy_n  = 1'b0;
                end
              end else if (state == ST_WADDR) begin
                ptr_n   = byte_in[AW-1:0];
                state_n = ST_WADDR_ACK;
              end else begin
                mem_we  = 1'b1;
                ptr_n   = ptr_inc;
                state_n = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall of an ACK slot pulls SDA low, the second one ends the slot.
        ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n      = 1'b0;
              bit_cnt_n = '0;
              if (state == ST_DEV_ACK && rw) begin
                shreg_n = rdata;
                oe_n    = ~rdata[7];
                ptr_n   = ptr_inc;
                state_n = ST_RDATA;
              end else if (state == ST_DEV_ACK) begin
                state_n = ST_WADDR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_n      = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_RD_MACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shreg_n   = {shreg[6:0], shreg[7]};
              oe_n      = ~shreg[6];
            end
          end
        end
        // A NACK leaves on the rise, so any fall seen here follows an ACK.
        ST_RD_MACK: begin
          if (scl_rise && sda_q == NACK) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
          end else if (scl_fall) begin
            shreg_n   = rdata;
            oe_n      = ~rdata[7];
            ptr_n     = ptr_inc;
            bit_cnt_n = '0;
            state_n   = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_OE   = oe;
  assign BUSY     = busy;
  assign WR_PULSE = wr_pulse;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed I2C master bench for i2c_eeprom_slave with an expected-byte scoreboard.
module tb_i2c_eeprom_slave;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_in, sda_oe, busy, wr_pulse;

  int tests = 0;
  int failed = 0;
  int wr_cnt = 0, busy_cyc = 0, oe_cyc = 0;
  int w0, b0, o0;
  logic [7:0] sb_q[$];

  assign sda_in = m_sda & ~sda_oe;

  always #10 clk = ~clk;

  i2c_eeprom_slave dut (
    .CLK_50M  (clk),
    .RSTn     (rst_n),
    .SCL      (scl),
    .SDA_IN   (sda_in),
    .SDA_OE   (sda_oe),
    .BUSY     (busy),
    .WR_PULSE (wr_pulse)
  );

  always @(posedge clk) begin
    if (wr_pulse === 1'b1) wr_cnt <= wr_cnt + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (sda_oe === 1'b1) oe_cyc <= oe_cyc + 1;
  end

  initial begin
    #(64'd4_000_000);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (sb_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {24'd0, obs}, {24'd0, exp});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    b = sda_in; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  // exp_ack: 0 when the responder must ACK, 1 when the line must stay high.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    sb_q.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    sb_check(tag, {7'd0, a});
  endtask

  task automatic recv_byte(input logic mack, input string tag);
    logic [7:0] d;
    logic bv;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(bv);
      d = {d[6:0], bv};
    end
    sb_check(tag, d);
    write_bit(mack);
  endtask

  task automatic read_from(input logic [7:0] addr, input string tag);
    i2c_start();
    send_byte(8'hA0, 1'b0, {tag, "_dev_w"});
    send_byte(addr, 1'b0, {tag, "_addr"});
    i2c_start();
    send_byte(8'hA1, 1'b0, {tag, "_dev_r"});
  endtask

  initial begin
    tick(4);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // byte write 0x5A to 0x10
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, 1'b0, "bw_dev");
    check("bw_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h10, 1'b0, "bw_addr");
    send_byte(8'h5A, 1'b0, "bw_data");
    i2c_stop();
    check("bw_wr_pulses", wr_cnt - w0, 32'd1);
    check("bw_busy_after_stop", {31'd0, busy}, 32'd0);

    // marker byte at 0x11 so the post-read pointer is observable
    i2c_start();
    send_byte(8'hA0, 1'b0, "pre_dev");
    send_byte(8'h11, 1'b0, "pre_addr");
    send_byte(8'hC3, 1'b0, "pre_data");
    i2c_stop();

    read_from(8'h10, "rr");
    sb_q.push_back(8'h5A);
    recv_byte(1'b1, "rr_data");
    check("rr_oe_after_nack", {31'd0, sda_oe}, 32'd0);
    check("rr_busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();

    i2c_start();
    send_byte(8'hA1, 1'b0, "cur_dev");
    sb_q.push_back(8'hC3);
    recv_byte(1'b1, "cur_data_ptr11");
    i2c_stop();

    // address mismatch
    w0 = wr_cnt; b0 = busy_cyc; o0 = oe_cyc;
    i2c_start();
    send_byte(8'hA2, 1'b1, "mm_dev");
    send_byte(8'h10, 1'b1, "mm_b1");
    send_byte(8'h55, 1'b1, "mm_b2");
    i2c_stop();
    check("mm_busy_cycles", busy_cyc - b0, 32'd0);
    check("mm_oe_cycles", oe_cyc - o0, 32'd0);
    check("mm_wr_pulses", wr_cnt - w0, 32'd0);

    // pointer wrap on write and read
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, 1'b0, "wr_dev");
    send_byte(8'hFE, 1'b0, "wr_addr");
    send_byte(8'h11, 1'b0, "wr_d0");
    send_byte(8'h22, 1'b0, "wr_d1");
    send_byte(8'h33, 1'b0, "wr_d2");
    i2c_stop();
    check("wr_wr_pulses", wr_cnt - w0, 32'd3);

    read_from(8'hFE, "wrd");
    sb_q.push_back(8'h11);
    recv_byte(1'b0, "wrd_fe");
    sb_q.push_back(8'h22);
    recv_byte(1'b0, "wrd_ff");
    sb_q.push_back(8'h33);
    recv_byte(1'b1, "wrd_00");
    i2c_stop();

    read_from(8'h00, "r00");
    sb_q.push_back(8'h33);
    recv_byte(1'b1, "r00_data");
    i2c_stop();

    // STOP after four data bits
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, 1'b0, "ab_dev");
    send_byte(8'h10, 1'b0, "ab_addr");
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    check("ab_wr_pulses", wr_cnt - w0, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    read_from(8'h10, "abr");
    sb_q.push_back(8'h5A);
    recv_byte(1'b1, "abr_data");
    i2c_stop();

    // reset while driving a zero bit of a read byte
    i2c_start();
    send_byte(8'hA0, 1'b0, "rz_dev");
    send_byte(8'h20, 1'b0, "rz_addr");
    send_byte(8'h00, 1'b0, "rz_data");
    i2c_stop();
    read_from(8'h20, "rst");
    check("rst_pre_oe", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    i2c_stop();
    read_from(8'h10, "post");
    sb_q.push_back(8'h5A);
    recv_byte(1'b1, "post_data");
    i2c_stop();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
